// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and entry definitions for the ALU result stage.
// Imported by alu_flag_gen and alu_result_stage.
package alu_pkg;

   localparam logic [2:0] OP_CLR = 3'b000;
   localparam logic [2:0] OP_BMA = 3'b001;
   localparam logic [2:0] OP_AMB = 3'b010;
   localparam logic [2:0] OP_ADD = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_AND = 3'b110;
   localparam logic [2:0] OP_SET = 3'b111;

   localparam int FLG_N = 3;
   localparam int FLG_Z = 2;
   localparam int FLG_C = 1;
   localparam int FLG_V = 0;

   localparam int ENTRY_W = 36;

   typedef struct packed {
      logic [31:0] f;
      logic [3:0]  flags;
   } entry_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational carry chain and {N,Z,C,V} flag generation for 8 slices.
// Optional V flag enabled by macro ALU_RESULT_OVF_EN.
module alu_flag_gen
   import alu_pkg::*;
(
   input  logic [31:0] f,
   input  logic [7:0]  g,
   input  logic [7:0]  p,
   input  logic        c_in,
   input  logic [2:0]  s,
   input  logic        a31,
   input  logic        b31,
   output logic [3:0]  flags
);

   logic cy;
   logic is_arith;
   logic ovf;

   // Ripple-lookahead carry across the eight slice g/p pairs
   always_comb begin
      cy = c_in;
      for (int k = 0; k < 8; k++) begin
         cy = g[k] | (p[k] & cy);
      end
   end

   assign is_arith = (s == OP_BMA) | (s == OP_AMB) | (s == OP_ADD);

`ifdef ALU_RESULT_OVF_EN
   // Signed overflow from operand and result sign bits
   always_comb begin
      ovf = 1'b0;
      case (s)
         OP_ADD:  ovf = (a31 == b31) & (f[31] != a31);
         OP_AMB:  ovf = (a31 != b31) & (f[31] != a31);
         OP_BMA:  ovf = (a31 != b31) & (f[31] != b31);
         default: ovf = 1'b0;
      endcase
   end
`else
   logic ovf_unused;
   assign ovf_unused = a31 ^ b31;
   assign ovf = 1'b0;
`endif

   // Pack flags into their fixed bit positions
   always_comb begin
      flags        = '0;
      flags[FLG_N] = f[31];
      flags[FLG_Z] = (f == 32'h0);
      flags[FLG_C] = is_arith & cy;
      flags[FLG_V] = ovf;
   end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: flag generation feeding a 2-entry output FIFO
// with a saturating pop counter. V flag optional via ALU_RESULT_OVF_EN.
module alu_result_stage
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_f,
   input  logic [7:0]  in_g,
   input  logic [7:0]  in_p,
   input  logic        in_c,
   input  logic [2:0]  in_s,
   input  logic        in_a31,
   input  logic        in_b31,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_f,
   output logic [3:0]  out_flags,
   output logic [15:0] out_count
);

   logic [1:0]  cnt_q, cnt_d;
   entry_t      mem0_q, mem0_d;
   entry_t      mem1_q, mem1_d;
   logic [15:0] count_q, count_d;
   logic [3:0]  new_flags;
   entry_t      new_entry;
   logic        push;
   logic        pop;

   alu_flag_gen u_flag_gen (
      .f     (in_f),
      .g     (in_g),
      .p     (in_p),
      .c_in  (in_c),
      .s     (in_s),
      .a31   (in_a31),
      .b31   (in_b31),
      .flags (new_flags)
   );

   assign new_entry = '{f: in_f, flags: new_flags};

   assign in_ready  = (cnt_q != 2'd2);
   assign out_valid = (cnt_q != 2'd0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   assign out_f     = mem0_q.f;
   assign out_flags = mem0_q.flags;
   assign out_count = count_q;

   // FIFO next state; mem0 is always the head entry
   always_comb begin
      cnt_d  = cnt_q;
      mem0_d = mem0_q;
      mem1_d = mem1_q;
      case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) mem0_d = new_entry;
            else               mem1_d = new_entry;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            mem0_d = mem1_q;
            cnt_d  = cnt_q - 2'd1;
         end
         2'b11: begin
            // only reachable with one entry held
            mem0_d = new_entry;
         end
         default: ;
      endcase
   end

   // Saturating count of popped results
   always_comb begin
      count_d = count_q;
      if (pop && (count_q != 16'hFFFF)) begin
         count_d = count_q + 16'd1;
      end
   end

   // State registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         mem0_q  <= '0;
         mem1_q  <= '0;
         count_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         mem0_q  <= mem0_d;
         mem1_q  <= mem1_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: vector table plus FIFO,
// backpressure, reset and counter-saturation sequences.
module tb_alu_result_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_f;
   logic [7:0]  in_g;
   logic [7:0]  in_p;
   logic        in_c;
   logic [2:0]  in_s;
   logic        in_a31;
   logic        in_b31;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_f;
   logic [3:0]  out_flags;
   logic [15:0] out_count;

`ifdef ALU_RESULT_OVF_EN
   localparam bit OVF = 1'b1;
`else
   localparam bit OVF = 1'b0;
`endif

   alu_result_stage dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_f      (in_f),
      .in_g      (in_g),
      .in_p      (in_p),
      .in_c      (in_c),
      .in_s      (in_s),
      .in_a31    (in_a31),
      .in_b31    (in_b31),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_f     (out_f),
      .out_flags (out_flags),
      .out_count (out_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  s;
      logic [31:0] f;
      logic [7:0]  g;
      logic [7:0]  p;
      logic        c;
      logic        a;
      logic        b;
      logic [3:0]  flags;
   } vec_t;

   typedef struct {
      logic [31:0] f;
      logic [3:0]  flags;
   } exp_t;

   exp_t        sb[$];
   exp_t        pending;
   logic [15:0] exp_count;
   int          n_chk;
   int          n_fail;
   exp_t        first_e;

   task automatic chk(string name, logic [35:0] act, logic [35:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] model(logic [2:0] s, logic [31:0] f,
                                        logic [7:0] g, logic [7:0] p,
                                        logic c, logic a, logic b);
      logic cy;
      logic v;
      cy = c;
      for (int k = 0; k < 8; k++) cy = g[k] | (p[k] & cy);
      v = 1'b0;
      if (OVF) begin
         if (s == 3'b011) v = (a == b) && (f[31] != a);
         if (s == 3'b010) v = (a != b) && (f[31] != a);
         if (s == 3'b001) v = (a != b) && (f[31] != b);
      end
      model = {f[31], f == 32'h0,
               (s == 3'b001 || s == 3'b010 || s == 3'b011) ? cy : 1'b0, v};
   endfunction

   task automatic drive(logic [2:0] s, logic [31:0] f, logic [7:0] g,
                        logic [7:0] p, logic c, logic a, logic b,
                        logic [3:0] fl);
      in_valid = 1'b1;
      in_s = s; in_f = f; in_g = g; in_p = p;
      in_c = c; in_a31 = a; in_b31 = b;
      pending.f = f;
      pending.flags = fl;
   endtask

   task automatic drive_rand();
      logic [2:0]  s;
      logic [31:0] f;
      logic [7:0]  g, p;
      logic        c, a, b;
      s = 3'($urandom_range(0, 7));
      f = $urandom;
      g = 8'($urandom);
      p = 8'($urandom);
      c = 1'($urandom);
      a = 1'($urandom);
      b = 1'($urandom);
      drive(s, f, g, p, c, a, b, model(s, f, g, p, c, a, b));
   endtask

   task automatic step();
      exp_t e;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("pop_empty", 36'(out_valid), 36'h0);
         end else begin
            e = sb.pop_front();
            chk("out_f", 36'(out_f), 36'(e.f));
            chk("out_flags", 36'(out_flags), 36'(e.flags));
         end
         if (exp_count != 16'hFFFF) exp_count++;
      end
      if (in_valid && in_ready) sb.push_back(pending);
      @(posedge clk);
      @(negedge clk);
      chk("out_valid", 36'(out_valid), 36'(sb.size() != 0));
      chk("in_ready", 36'(in_ready), 36'(sb.size() < 2));
      chk("out_count", 36'(out_count), 36'(exp_count));
   endtask

   task automatic drain();
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 8 && sb.size() != 0; i++) step();
      chk("drain_done", 36'(sb.size()), 36'h0);
   endtask

   vec_t vt[13];

   initial begin
      n_chk = 0;
      n_fail = 0;
      exp_count = '0;
      vt[0]  = '{3'b011, 32'h0000_0000, 8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 4'b0110};
      vt[1]  = '{3'b011, 32'h0000_0000, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 4'b0110};
      vt[2]  = '{3'b100, 32'h0000_0000, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 4'b0100};
      vt[3]  = '{3'b011, 32'h8000_0000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 4'b1001};
      vt[4]  = '{3'b010, 32'h0000_0001, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 4'b0001};
      vt[5]  = '{3'b001, 32'h8000_0000, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b0, 4'b1011};
      vt[6]  = '{3'b101, 32'hFFFF_FFFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 4'b1000};
      vt[7]  = '{3'b111, 32'hFFFF_FFFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 4'b1000};
      vt[8]  = '{3'b110, 32'h0000_0000, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 4'b0100};
      vt[9]  = '{3'b000, 32'h0000_0000, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 4'b0100};
      vt[10] = '{3'b011, 32'h7FFF_FFFF, 8'h00, 8'h7F, 1'b1, 1'b1, 1'b1, 4'b0001};
      vt[11] = '{3'b011, 32'h1234_5678, 8'h00, 8'hFE, 1'b1, 1'b0, 1'b1, 4'b0000};
      vt[12] = '{3'b011, 32'h0000_0010, 8'h40, 8'h80, 1'b0, 1'b0, 1'b0, 4'b0010};

      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      in_f = '0; in_g = '0; in_p = '0; in_c = 1'b0;
      in_s = '0; in_a31 = 1'b0; in_b31 = 1'b0;
      #12;
      chk("rst_out_valid", 36'(out_valid), 36'h0);
      chk("rst_in_ready", 36'(in_ready), 36'h1);
      chk("rst_out_f", 36'(out_f), 36'h0);
      chk("rst_out_flags", 36'(out_flags), 36'h0);
      chk("rst_out_count", 36'(out_count), 36'h0);
      @(negedge clk);
      rst = 1'b0;

      // table: stream every vector with the sink always ready
      out_ready = 1'b1;
      foreach (vt[i]) begin
         drive(vt[i].s, vt[i].f, vt[i].g, vt[i].p, vt[i].c,
               vt[i].a, vt[i].b,
               OVF ? vt[i].flags : {vt[i].flags[3:1], 1'b0});
         step();
      end
      drain();

      // backpressure: third push must be refused
      out_ready = 1'b0;
      drive_rand();
      first_e = pending;
      step();
      drive_rand();
      step();
      chk("full_in_ready", 36'(in_ready), 36'h0);
      drive_rand();
      step();
      chk("hold_head_f", 36'(out_f), 36'(first_e.f));
      chk("hold_head_flags", 36'(out_flags), 36'(first_e.flags));
      drain();
      chk("bp_count", 36'(out_count), 36'(exp_count));

      // one held entry, then push+pop in the same cycle 10 times
      out_ready = 1'b0;
      drive_rand();
      step();
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive_rand();
         step();
         chk("stream_occ", 36'(sb.size()), 36'h1);
      end
      drain();

      // reset with two entries held
      out_ready = 1'b0;
      drive_rand();
      step();
      drive_rand();
      step();
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", 36'(out_valid), 36'h0);
      chk("mid_rst_in_ready", 36'(in_ready), 36'h1);
      chk("mid_rst_out_count", 36'(out_count), 36'h0);
      sb.delete();
      exp_count = '0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_out_valid", 36'(out_valid), 36'h0);

      // counter saturation from 16'hFFFE
      force dut.count_q = 16'hFFFE;
      @(posedge clk);
      @(negedge clk);
      release dut.count_q;
      exp_count = 16'hFFFE;
      @(negedge clk);
      chk("forced_count", 36'(out_count), 36'hFFFE);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive_rand();
         step();
      end
      drain();
      chk("sat_count", 36'(out_count), 36'hFFFF);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
